// File: rtl/switch_debounce.sv
`default_nettype none
// =====================================================================
// Module   : switch_debounce
// Brief    : Synchronizes and debounces a mechanical switch input.
// Revision : 1.0
// =====================================================================

module switch_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic SW,
   output logic D,
   output logic rise,
   output logic fall,
   output logic stable
);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(STABLE_CYCLES - 1);

   logic                 r_s1;
   logic                 r_s2;
   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic                 r_d;
   logic                 w_d_nxt;
   logic                 r_rise;
   logic                 w_rise_nxt;
   logic                 r_fall;
   logic                 w_fall_nxt;
   logic                 r_stable;
   logic                 w_stable_nxt;

   // Two-flop synchronizer; nothing downstream sees SW directly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= SW;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE_LOW;
         r_cnt    <= '0;
         r_d      <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_stable <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_d      <= w_d_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
         r_stable <= w_stable_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_d_nxt     = r_d;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         IDLE_LOW: begin
            if (r_s2) begin
               w_state_nxt = WAIT_HIGH;
               w_cnt_nxt   = c_cnt_one;
            end
         end
         WAIT_HIGH: begin
            if (!r_s2) begin
               w_state_nxt = IDLE_LOW;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = IDLE_HIGH;
               w_d_nxt     = 1'b1;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_one;
            end
         end
         IDLE_HIGH: begin
            if (!r_s2) begin
               w_state_nxt = WAIT_LOW;
               w_cnt_nxt   = c_cnt_one;
            end
         end
         WAIT_LOW: begin
            if (r_s2) begin
               w_state_nxt = IDLE_HIGH;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = IDLE_LOW;
               w_d_nxt     = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_one;
            end
         end
         default: begin
            w_state_nxt = IDLE_LOW;
            w_d_nxt     = 1'b0;
         end
      endcase
      // Registered from the next state so stable lines up with D.
      w_stable_nxt = (w_state_nxt == IDLE_LOW) || (w_state_nxt == IDLE_HIGH);
   end

   assign D      = r_d;
   assign rise   = r_rise;
   assign fall   = r_fall;
   assign stable = r_stable;

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// =====================================================================
// Module   : tb_switch_debounce
// Brief    : Directed self-checking bench for switch_debounce.
// Revision : 1.0
// =====================================================================

module tb_switch_debounce;

   logic clk;
   logic reset;
   logic SW;
   logic D;
   logic rise;
   logic fall;
   logic stable;
   logic dsw_q;

   int n_cmp;
   int n_err;

   switch_debounce #(
      .STABLE_CYCLES(4),
      .CNT_WIDTH    (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .SW    (SW),
      .D     (D),
      .rise  (rise),
      .fall  (fall),
      .stable(stable)
   );

   // Downstream DSwitch register fed by the debounced level.
   always @(posedge clk or negedge reset) begin
      if (!reset) dsw_q <= 1'b0;
      else        dsw_q <= D;
   end

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      SW    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if ({D, rise, fall, stable} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_hold: {D,rise,fall,stable}=%b expected 0001", {D, rise, fall, stable});
         end
      end
   endtask

   // SW already high at release behaves as a fresh 0->1 change.
   task automatic test_rise;
      logic d_pos;
      reset = 1'b1;
      SW    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (D !== 1'b0 || rise !== 1'b0 || stable !== (i < 2)) begin
            n_err++;
            $display("FAIL rise_wait[%0d]: D=%b rise=%b stable=%b expected 0 0 %b", i, D, rise, stable, (i < 2));
         end
         d_pos = D;
         @(negedge clk);
         #1;
         n_cmp++;
         if (D !== d_pos) begin
            n_err++;
            $display("FAIL rise_negedge[%0d]: D=%b expected %b", i, D, d_pos);
         end
      end
      step();
      n_cmp++;
      if ({D, rise, fall, stable} !== 4'b1101) begin
         n_err++;
         $display("FAIL rise_edge: {D,rise,fall,stable}=%b expected 1101", {D, rise, fall, stable});
      end
      step();
      n_cmp++;
      if ({D, rise, fall, stable} !== 4'b1001) begin
         n_err++;
         $display("FAIL rise_after: {D,rise,fall,stable}=%b expected 1001", {D, rise, fall, stable});
      end
   endtask

   // Low pulses of STABLE_CYCLES-1 synchronized cycles must be rejected.
   task automatic test_glitch_low;
      for (int r = 0; r < 2; r++) begin
         SW = 1'b0;
         for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (D !== 1'b1 || fall !== 1'b0 || rise !== 1'b0) begin
               n_err++;
               $display("FAIL glitch_low: D=%b fall=%b rise=%b expected 1 0 0", D, fall, rise);
            end
         end
         SW = 1'b1;
         for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (D !== 1'b1 || fall !== 1'b0 || rise !== 1'b0) begin
               n_err++;
               $display("FAIL glitch_low_rec: D=%b fall=%b rise=%b expected 1 0 0", D, fall, rise);
            end
         end
      end
      n_cmp++;
      if (stable !== 1'b1) begin
         n_err++;
         $display("FAIL glitch_low_stable: stable=%b expected 1", stable);
      end
   endtask

   task automatic test_fall;
      SW = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (D !== 1'b1 || fall !== 1'b0 || stable !== (i < 2)) begin
            n_err++;
            $display("FAIL fall_wait[%0d]: D=%b fall=%b stable=%b expected 1 0 %b", i, D, fall, stable, (i < 2));
         end
      end
      step();
      n_cmp++;
      if ({D, rise, fall, stable} !== 4'b0011) begin
         n_err++;
         $display("FAIL fall_edge: {D,rise,fall,stable}=%b expected 0011", {D, rise, fall, stable});
      end
      step();
      n_cmp++;
      if ({D, rise, fall, stable} !== 4'b0001) begin
         n_err++;
         $display("FAIL fall_after: {D,rise,fall,stable}=%b expected 0001", {D, rise, fall, stable});
      end
   endtask

   task automatic test_glitch_high;
      for (int r = 0; r < 3; r++) begin
         SW = 1'b1;
         for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (D !== 1'b0 || rise !== 1'b0) begin
               n_err++;
               $display("FAIL glitch_high: D=%b rise=%b expected 0 0", D, rise);
            end
         end
         SW = 1'b0;
         for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (D !== 1'b0 || rise !== 1'b0) begin
               n_err++;
               $display("FAIL glitch_high_low: D=%b rise=%b expected 0 0", D, rise);
            end
         end
      end
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if ({D, rise, fall, stable} !== 4'b0001) begin
         n_err++;
         $display("FAIL glitch_high_settle: {D,rise,fall,stable}=%b expected 0001", {D, rise, fall, stable});
      end
   endtask

   task automatic test_reset_async;
      SW = 1'b1;
      for (int i = 0; i < 6; i++) step();
      n_cmp++;
      if (D !== 1'b1) begin
         n_err++;
         $display("FAIL async_pre: D=%b expected 1", D);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({D, rise, fall, stable} !== 4'b0001) begin
         n_err++;
         $display("FAIL async_from_high: {D,rise,fall,stable}=%b expected 0001", {D, rise, fall, stable});
      end
      SW = 1'b0;
      step();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step();
   endtask

   task automatic test_reset_mid_wait;
      SW = 1'b1;
      for (int i = 0; i < 3; i++) step();
      n_cmp++;
      if (stable !== 1'b0 || D !== 1'b0) begin
         n_err++;
         $display("FAIL midwait_pre: stable=%b D=%b expected 0 0", stable, D);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({D, rise, fall, stable} !== 4'b0001) begin
         n_err++;
         $display("FAIL midwait_reset: {D,rise,fall,stable}=%b expected 0001", {D, rise, fall, stable});
      end
      SW = 1'b0;
      step();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++;
         if (D !== 1'b0 || rise !== 1'b0) begin
            n_err++;
            $display("FAIL midwait_after[%0d]: D=%b rise=%b expected 0 0", i, D, rise);
         end
      end
   endtask

   task automatic test_dswitch;
      logic prev_d;
      logic q_pos;
      for (int i = 0; i < 24; i++) begin
         SW     = ((i / 8) % 2 == 0);
         prev_d = D;
         step();
         n_cmp++;
         if (dsw_q !== prev_d) begin
            n_err++;
            $display("FAIL dswitch[%0d]: Q=%b expected %b", i, dsw_q, prev_d);
         end
         q_pos = dsw_q;
         @(negedge clk);
         #1;
         n_cmp++;
         if (dsw_q !== q_pos) begin
            n_err++;
            $display("FAIL dswitch_negedge[%0d]: Q=%b expected %b", i, dsw_q, q_pos);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      SW    = 1'b1;
      test_reset();
      test_rise();
      test_glitch_low();
      test_fall();
      test_glitch_high();
      test_reset_async();
      test_reset_mid_wait();
      test_dswitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive synchronized-equal samples required to accept a new switch level; legal range 2..65535.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the stability counter width, with STABLE_CYCLES <= 2^CNT_WIDTH - 1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-005 SW  input  1  raw mechanical switch level, asynchronous to clk, may bounce.
REQ-006 D  output  1  debounced registered switch level; drives D of the downstream DSwitch register.
REQ-007 rise  output  1  one-cycle registered pulse when D goes 0->1.
REQ-008 fall  output  1  one-cycle registered pulse when D goes 1->0.
REQ-009 stable  output  1  high when FSM is in IDLE_LOW or IDLE_HIGH.

Function
REQ-010 SW SHALL pass through a two-flop synchronizer (s1, s2) before any other logic; no logic SHALL use SW directly.
REQ-011 FSM states SHALL be IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-012 IDLE_LOW: s2=1 -> WAIT_HIGH with cnt=1; else stay, cnt=0.
REQ-013 WAIT_HIGH: s2=0 -> IDLE_LOW, cnt=0, D unchanged; s2=1 and cnt=STABLE_CYCLES-1 -> IDLE_HIGH, D=1, rise=1, cnt=0; otherwise cnt+1.
REQ-014 IDLE_HIGH: s2=0 -> WAIT_LOW with cnt=1; else stay, cnt=0.
REQ-015 WAIT_LOW: s2=1 -> IDLE_HIGH, cnt=0, D unchanged; s2=0 and cnt=STABLE_CYCLES-1 -> IDLE_LOW, D=0, fall=1, cnt=0; otherwise cnt+1.
REQ-016 rise and fall SHALL be high for exactly one cycle, coincident with the D edge, and never both high.
REQ-017 Latency: SW changed and held before rising edge k SHALL produce the D change at rising edge k+1+STABLE_CYCLES (edge k+5 at default).
REQ-018 Any s2 reversal during WAIT_* SHALL restart qualification; a glitch shorter than STABLE_CYCLES synchronized cycles SHALL never change D or pulse rise/fall.
REQ-019 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-020 D, rise, fall, stable SHALL be registered outputs with no combinational path from SW, and SHALL not change on falling edges of clk.

Reset
REQ-021 While reset=0: s1=s2=0, state=IDLE_LOW, cnt=0, D=0, rise=0, fall=0, stable=1, regardless of SW or clk.
REQ-022 Reset asserted mid-WAIT_HIGH or WAIT_LOW SHALL abort qualification with no rise/fall pulse emitted.
REQ-023 After reset=1, SW already high SHALL be treated as a new 0->1 change, D=1 at edge k+1+STABLE_CYCLES from first sampling edge k.

Verification (CLK_PERIOD=20, STABLE_CYCLES=4)
REQ-024 reset=0 for one period, SW=1, clk toggling -> D=0, rise=fall=0, stable=1 throughout.
REQ-025 reset=1, SW 0->1 held before edge k -> D=0 through edge k+4, D=1 and rise=1 after edge k+5, rise=0 after edge k+6, stable=1 after edge k+5; D unchanged at every falling edge.
REQ-026 From D=1, SW 1->0 held -> D=0 and fall=1 after edge k+5, single pulse.
REQ-027 From D=0, SW high 2 cycles then low, repeated 3 times -> D=0, rise=0 throughout, stable returns to 1.
REQ-028 SW high 3 cycles then reset=0 mid-WAIT_HIGH then reset=1 with SW=0 -> D=0 immediately on reset, no rise pulse for 10 cycles after release.
REQ-029 switch_debounce D feeding DSwitch -> DSwitch Q equals debounced D one rising edge later, Q never changes on a falling edge.
